alu_seq: RTL

- Parametrised, handshaked successor of the 4-bit datapath ALU, with configurable WIDTH.
- Registered result and persistent flags register. Adds carry/borrow-chained ops, shifts, and an iterative shift-add multiplier that takes multiple cycles.
- Sits between the instruction decoder (operand/opcode issue) and the register-file writeback; in_ready stalls the decoder during multi-cycle ops.

---
 rtl/alu_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result and persistent
// flags, carry/borrow chaining, shifts and an iterative shift-add multiplier.
module alu_seq #(
    parameter int WIDTH      = 4,
    parameter bit CMP_SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flag,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] WLIM = (WIDTH + 1)'(WIDTH);

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_CMP = 4'd6,
        OP_ADC = 4'd7,
        OP_SBB = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10,
        OP_MUL = 4'd11,
        OP_CLF = 4'd12
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state, state_n;

    logic [2*WIDTH-1:0] acc, acc_n, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               mul_last;

    logic [WIDTH:0]   add_s, adc_s, sbb_rhs, sbb_d;
    logic [WIDTH-1:0] res_d;
    logic [4:0]       flag_d;
    logic             ill_d;
    logic             big_shift;
    logic             lt, gt, eq;

    assign in_ready = (state == S_IDLE);
    assign mul_last = (count == CW'(1));
    assign acc_n    = acc + (mplier[0] ? mcand : '0);

    // Arithmetic building blocks shared by the opcode decoder.
    always_comb begin
        add_s     = {1'b0, a} + {1'b0, b};
        adc_s     = add_s + {{WIDTH{1'b0}}, flag[1]};
        sbb_rhs   = {1'b0, b} + {{WIDTH{1'b0}}, flag[0]};
        sbb_d     = {1'b0, a} - sbb_rhs;
        big_shift = ({1'b0, b} >= WLIM);
        if (CMP_SIGNED) begin
            lt = ($signed(a) < $signed(b));
            gt = ($signed(a) > $signed(b));
        end else begin
            lt = (a < b);
            gt = (a > b);
        end
        eq = (a == b);
    end

    // Single-cycle result, next flags and illegal-opcode detection.
    always_comb begin
        res_d  = '0;
        flag_d = flag;
        ill_d  = 1'b0;
        case (opcode)
            OP_NOP: res_d = '0;
            OP_ADD: begin
                res_d     = add_s[WIDTH-1:0];
                flag_d[1] = add_s[WIDTH];
            end
            OP_SUB: begin
                res_d     = a - b;
                flag_d[0] = (a < b);
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_CMP: flag_d[4:2] = {lt, gt, eq};
            OP_ADC: begin
                res_d     = adc_s[WIDTH-1:0];
                flag_d[1] = adc_s[WIDTH];
            end
            OP_SBB: begin
                res_d     = sbb_d[WIDTH-1:0];
                flag_d[0] = ({1'b0, a} < sbb_rhs);
            end
            OP_SHL: res_d = big_shift ? '0 : (a << b);
            OP_SHR: res_d = big_shift ? '0 : (a >> b);
            OP_MUL: res_d = '0;
            OP_CLF: flag_d = '0;
            default: ill_d = 1'b1;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Enter MUL on a multiply accept, leave on the final step.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (in_valid && opcode == OP_MUL) state_n = S_MUL;
            S_MUL:  if (mul_last) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Result/flag registers and the shift-add multiplier datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            result_hi <= '0;
            flag      <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            if (state == S_MUL) begin
                acc    <= acc_n;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - CW'(1);
                if (mul_last) begin
                    {result_hi, result} <= acc_n;
                    out_valid           <= 1'b1;
                end
            end else if (in_valid) begin
                if (opcode == OP_MUL) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    count  <= CW'(WIDTH);
                end else begin
                    result    <= res_d;
                    result_hi <= '0;
                    flag      <= flag_d;
                    illegal   <= ill_d;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
